// File: rtl/uart_word_sequencer_if.sv
// Interface bundling the producer push port and the LCDC transmit handshake
// of uart_word_sequencer. The sequencer takes the slave view; whoever drives
// pushes and models LCDC READY takes the master view.
interface uart_word_sequencer_if #(
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_W      = 16
);
    logic                  PUSH;
    logic [31:0]           PUSH_DATA;
    logic                  PUSH_LAST;
    logic                  FULL;
    logic                  EMPTY;
    logic [DEPTH_LOG2:0]   LEVEL;
    logic                  OVERFLOW;
    logic [31:0]           TX_DATA;
    logic                  TX_WE;
    logic                  TX_READY;
    logic                  BUSY;
    logic [CNT_W-1:0]      SENT_COUNT;

    modport slave (
        input  PUSH, PUSH_DATA, PUSH_LAST, TX_READY,
        output FULL, EMPTY, LEVEL, OVERFLOW, TX_DATA, TX_WE, BUSY, SENT_COUNT
    );

    modport master (
        output PUSH, PUSH_DATA, PUSH_LAST, TX_READY,
        input  FULL, EMPTY, LEVEL, OVERFLOW, TX_DATA, TX_WE, BUSY, SENT_COUNT
    );
endinterface

// File: rtl/uart_word_sequencer.sv
// uart_word_sequencer: queues 32-bit result words and hands them one at a
// time to the LCDC UART hex printer using its WE/READY handshake.
// Optional feature macro: TXQ_CHECKSUM_EN -- when defined, each frame (closed
// by a word pushed with PUSH_LAST) is followed by a trailer word holding the
// modulo-2^32 sum of the frame's data words.
module uart_word_sequencer #(
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK1,
    input  logic                  RST_X,
    uart_word_sequencer_if.slave  bus
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2 + 1;

`ifdef TXQ_CHECKSUM_EN
    localparam int ENTRY_W = 33;
    typedef enum logic [1:0] {ST_IDLE, ST_SENT, ST_WAIT, ST_TRAIL} state_t;
`else
    localparam int ENTRY_W = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_SENT, ST_WAIT} state_t;
`endif

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   level_q, level_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               overflow_q, overflow_d;
    logic [31:0]        tx_data_q, tx_data_d;
    logic               tx_we_q, tx_we_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   sent_count_q, sent_count_d;
    state_t             state_q, state_d;

    logic               push_ok;
    logic               pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [31:0]        head_data;

`ifdef TXQ_CHECKSUM_EN
    logic [31:0]        sum_q, sum_d;
    logic               last_pend_q, last_pend_d;
    logic               head_last;

    assign push_entry = {bus.PUSH_LAST, bus.PUSH_DATA};
    assign head_last  = head_entry[32];
`else
    logic               unused_push_last;

    assign unused_push_last = bus.PUSH_LAST;
    assign push_entry       = bus.PUSH_DATA;
`endif

    assign push_ok    = bus.PUSH && !full_q;
    assign head_entry = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign head_data  = head_entry[31:0];

    // Queue storage: written only on an accepted push, so a word becomes poppable one cycle later.
    always_ff @(posedge CLK1) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_entry;
        end
    end

    // Next pointers and registered flags; a push into a full queue is dropped even when a pop frees a slot.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = wr_ptr_d - rd_ptr_d;
        empty_d    = (wr_ptr_d == rd_ptr_d);
        full_d     = (wr_ptr_d[DEPTH_LOG2] != rd_ptr_d[DEPTH_LOG2]) &&
                     (wr_ptr_d[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]);
        overflow_d = overflow_q | (bus.PUSH & full_q);
    end

    // Transmit FSM: issue one word, wait for LCDC to drop then re-raise READY before the next issue.
    always_comb begin
        state_d      = state_q;
        tx_we_d      = 1'b0;
        tx_data_d    = tx_data_q;
        sent_count_d = sent_count_q;
        pop          = 1'b0;
`ifdef TXQ_CHECKSUM_EN
        sum_d        = sum_q;
        last_pend_d  = last_pend_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && bus.TX_READY) begin
                    tx_data_d    = head_data;
                    tx_we_d      = 1'b1;
                    pop          = 1'b1;
                    sent_count_d = sent_count_q + CNT_W'(1);
                    state_d      = ST_SENT;
`ifdef TXQ_CHECKSUM_EN
                    sum_d        = sum_q + head_data;
                    last_pend_d  = head_last;
`endif
                end
            end
            ST_SENT: begin
                if (!bus.TX_READY) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.TX_READY) begin
`ifdef TXQ_CHECKSUM_EN
                    state_d = last_pend_q ? ST_TRAIL : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef TXQ_CHECKSUM_EN
            ST_TRAIL: begin
                if (bus.TX_READY) begin
                    tx_data_d    = sum_q;
                    tx_we_d      = 1'b1;
                    sent_count_d = sent_count_q + CNT_W'(1);
                    sum_d        = '0;
                    last_pend_d  = 1'b0;
                    state_d      = ST_SENT;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State register; reset discards queued words and anything in flight.
    always_ff @(posedge CLK1 or negedge RST_X) begin
        if (!RST_X) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            overflow_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_we_q      <= 1'b0;
            busy_q       <= 1'b0;
            sent_count_q <= '0;
            state_q      <= ST_IDLE;
`ifdef TXQ_CHECKSUM_EN
            sum_q        <= '0;
            last_pend_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            overflow_q   <= overflow_d;
            tx_data_q    <= tx_data_d;
            tx_we_q      <= tx_we_d;
            busy_q       <= busy_d;
            sent_count_q <= sent_count_d;
            state_q      <= state_d;
`ifdef TXQ_CHECKSUM_EN
            sum_q        <= sum_d;
            last_pend_q  <= last_pend_d;
`endif
        end
    end

    assign bus.FULL       = full_q;
    assign bus.EMPTY      = empty_q;
    assign bus.LEVEL      = level_q;
    assign bus.OVERFLOW   = overflow_q;
    assign bus.TX_DATA    = tx_data_q;
    assign bus.TX_WE      = tx_we_q;
    assign bus.BUSY       = busy_q;
    assign bus.SENT_COUNT = sent_count_q;

endmodule
